score_table_reader: RTL and testbench

Read-back engine for the random-walk score table. After the random-walk/scoring pass has written per-node scores into BRAM at `SCORE_TABLE_OFFSET + node`, this block scans nodes 1..NODE_NUM. It issues single-port BRAM reads and streams `(node, score)` pairs out over a valid/ready handshake, while tracking the arg-max node. It sits between the shared BRAM port and the result/host interface, and is the reader for the score-table writer.

---
 rtl/score_table_reader.sv | 150 +++++++++++++++
 tb/tb_score_table_reader.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_table_reader.sv
// score_table_reader
//
// Scans the score table that the random-walk pass left in BRAM and streams
// (node, score) pairs for nodes 1..NODE_NUM over a valid/ready handshake.
// It tracks the arg-max node while it scans. Node n is stored at
// SCORE_TABLE_OFFSET + n. The BRAM read latency is one cycle.
//
// Ports:
//   i_clk, i_rst          clock; synchronous active-high reset
//   i_start               begin a scan (sampled only in idle)
//   o_busy, o_done        scan in progress; one-cycle completion pulse
//   o_addr, o_write,      BRAM port (read-only use; write tied off)
//   o_wdata, i_rdata
//   o_valid, i_ready      stream handshake
//   o_node, o_score       current beat payload
//   o_max_node,           arg-max node and its score for the current or
//   o_max_score           last scan
module score_table_reader #(
    parameter int unsigned ADDR_WIDTH         = 13,
    parameter int unsigned DATA_WIDTH         = 32,
    parameter int unsigned SCORE_TABLE_OFFSET = 100,
    parameter int unsigned NODE_NUM           = 100,
    parameter bit          SKIP_ZERO          = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_write,
    output logic [DATA_WIDTH-1:0] o_wdata,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [ADDR_WIDTH-1:0] o_node,
    output logic [DATA_WIDTH-1:0] o_score,
    output logic [ADDR_WIDTH-1:0] o_max_node,
    output logic [DATA_WIDTH-1:0] o_max_score
);

    localparam logic [ADDR_WIDTH-1:0] Offset   = ADDR_WIDTH'(SCORE_TABLE_OFFSET);
    localparam logic [ADDR_WIDTH-1:0] LastNode = ADDR_WIDTH'(NODE_NUM);
    localparam logic [ADDR_WIDTH-1:0] One      = ADDR_WIDTH'(1);

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StCap,
        StOut,
        StDone
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   node_q, node_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]   out_node_q, out_node_d;
    logic [DATA_WIDTH-1:0]   out_score_q, out_score_d;
    logic [ADDR_WIDTH-1:0]   max_node_q, max_node_d;
    logic [DATA_WIDTH-1:0]   max_score_q, max_score_d;
    logic                    advance;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= StIdle;
            node_q      <= '0;
            addr_q      <= '0;
            out_node_q  <= '0;
            out_score_q <= '0;
            max_node_q  <= '0;
            max_score_q <= '0;
        end else begin
            state_q     <= state_d;
            node_q      <= node_d;
            addr_q      <= addr_d;
            out_node_q  <= out_node_d;
            out_score_q <= out_score_d;
            max_node_q  <= max_node_d;
            max_score_q <= max_score_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        node_d      = node_q;
        addr_d      = addr_q;
        out_node_d  = out_node_q;
        out_score_d = out_score_q;
        max_node_d  = max_node_q;
        max_score_d = max_score_q;
        advance     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    node_d      = One;
                    addr_d      = Offset + One;
                    max_node_d  = '0;
                    max_score_d = '0;
                    state_d     = StRd;
                end
            end
            // Address is presented; the BRAM samples it on this edge.
            StRd: state_d = StCap;
            StCap: begin
                out_score_d = i_rdata;
                out_node_d  = node_q;
                // Strict compare keeps the lower node on ties.
                if (i_rdata > max_score_q) begin
                    max_score_d = i_rdata;
                    max_node_d  = node_q;
                end
                if (SKIP_ZERO && (i_rdata == '0)) begin
                    advance = 1'b1;
                end else begin
                    state_d = StOut;
                end
            end
            StOut: begin
                if (i_ready) begin
                    advance = 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (advance) begin
            if (node_q == LastNode) begin
                state_d = StDone;
            end else begin
                node_d  = node_q + One;
                addr_d  = Offset + node_q + One;
                state_d = StRd;
            end
        end
    end

    assign o_busy      = (state_q != StIdle);
    assign o_done      = (state_q == StDone);
    assign o_valid     = (state_q == StOut);
    assign o_addr      = addr_q;
    assign o_write     = 1'b0;
    assign o_wdata     = '0;
    assign o_node      = out_node_q;
    assign o_score     = out_score_q;
    assign o_max_node  = max_node_q;
    assign o_max_score = max_score_q;

endmodule

// File: tb/tb_score_table_reader.sv
// Directed bench for score_table_reader with NODE_NUM=4, offset 100.
// Instance a uses SKIP_ZERO=1 and carries the main stimulus; instance b uses
// SKIP_ZERO=0 with i_ready tied high and shares the BRAM contents.
module tb_score_table_reader;

    localparam int unsigned AW = 13;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start;
    logic          ready_a, ready_plain, bp_mode, ready_b;
    logic          bp_ready = 1'b0;
    int            stall = 0;
    logic          busy_a, done_a, write_a, valid_a;
    logic          busy_b, done_b, write_b, valid_b;
    logic [AW-1:0] addr_a, node_a, max_node_a, addr_b, node_b, max_node_b;
    logic [DW-1:0] wdata_a, score_a, max_score_a, rdata_a;
    logic [DW-1:0] wdata_b, score_b, max_score_b, rdata_b;
    logic [DW-1:0] mem [0:255];

    assign ready_b = 1'b1;
    assign ready_a = bp_mode ? bp_ready : ready_plain;

    score_table_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SCORE_TABLE_OFFSET(100),
                         .NODE_NUM(4), .SKIP_ZERO(1'b1)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_start(start), .o_busy(busy_a), .o_done(done_a),
        .o_addr(addr_a), .o_write(write_a), .o_wdata(wdata_a), .i_rdata(rdata_a),
        .o_valid(valid_a), .i_ready(ready_a), .o_node(node_a), .o_score(score_a),
        .o_max_node(max_node_a), .o_max_score(max_score_a)
    );

    score_table_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SCORE_TABLE_OFFSET(100),
                         .NODE_NUM(4), .SKIP_ZERO(1'b0)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(start), .o_busy(busy_b), .o_done(done_b),
        .o_addr(addr_b), .o_write(write_b), .o_wdata(wdata_b), .i_rdata(rdata_b),
        .o_valid(valid_b), .i_ready(ready_b), .o_node(node_b), .o_score(score_b),
        .o_max_node(max_node_b), .o_max_score(max_score_b)
    );

    // One-cycle-latency BRAM model
    always @(posedge clk) begin
        rdata_a <= mem[addr_a[7:0]];
        rdata_b <= mem[addr_b[7:0]];
    end

    // Backpressure: each beat sees i_ready low for 5 cycles, then high.
    always @(posedge clk) begin
        #2;
        if (valid_a) begin
            if (stall >= 5) begin
                bp_ready = 1'b1;
            end else begin
                bp_ready = 1'b0;
                stall++;
            end
        end else begin
            bp_ready = 1'b0;
            stall = 0;
        end
    end

    // Monitor, sampled mid-cycle
    int            cyc = 0, start_abs = 0, done_abs = 0, first_valid_abs = 0;
    logic          fv_pend = 1'b0;
    logic [AW-1:0] bn_a [0:63];
    logic [DW-1:0] bs_a [0:63];
    logic [AW-1:0] bn_b [0:63];
    logic [DW-1:0] bs_b [0:63];
    logic [AW-1:0] alog [0:63];
    int            na = 0, nb = 0, nal = 0, done_cnt_a = 0, done_cnt_b = 0;
    int            hold_cnt = 0, hold_bad = 0;
    logic          prev_hold = 1'b0, prev_rst = 1'b1, prev_valid = 1'b0;
    logic [AW-1:0] prev_node = '0, last_addr = '0;
    logic [DW-1:0] prev_score = '0;
    logic          write_seen = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (start && !busy_a) begin
            start_abs = cyc;
            fv_pend = 1'b1;
        end
        if (valid_a && !prev_valid && fv_pend) begin
            first_valid_abs = cyc;
            fv_pend = 1'b0;
        end
        if (prev_hold && !prev_rst) begin
            hold_cnt++;
            if (!valid_a || node_a != prev_node || score_a != prev_score) hold_bad++;
        end
        if (valid_a && ready_a && na < 64) begin
            bn_a[na] = node_a;
            bs_a[na] = score_a;
            na++;
        end
        if (valid_b && ready_b && nb < 64) begin
            bn_b[nb] = node_b;
            bs_b[nb] = score_b;
            nb++;
        end
        if (done_a) begin
            done_cnt_a++;
            done_abs = cyc;
        end
        if (done_b) done_cnt_b++;
        if (addr_a != last_addr) begin
            if (addr_a != '0 && nal < 64) begin
                alog[nal] = addr_a;
                nal++;
            end
            last_addr = addr_a;
        end
        if (write_a || write_b || wdata_a != '0 || wdata_b != '0) write_seen = 1'b1;
        prev_hold  = valid_a && !ready_a;
        prev_node  = node_a;
        prev_score = score_a;
        prev_valid = valid_a;
        prev_rst   = rst;
    end

    int n_chk = 0, n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic load(input int s1, input int s2, input int s3, input int s4);
        mem[101] = DW'(s1);
        mem[102] = DW'(s2);
        mem[103] = DW'(s3);
        mem[104] = DW'(s4);
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #2 start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
    endtask

    task automatic wait_idle(input int d0);
        logic ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (done_cnt_a != d0 && !busy_a && !busy_b) begin
                ok = 1'b1;
                break;
            end
        end
        check("scan_timeout", 64'(ok), 64'd1);
    endtask

    task automatic check_10n_beats(input string tag, input int b0);
        check({tag, "_beats"}, 64'(na - b0), 64'd4);
        for (int k = 0; k < 4; k++) begin
            check({tag, "_node"}, 64'(bn_a[b0 + k]), 64'(k + 1));
            check({tag, "_score"}, 64'(bs_a[b0 + k]), 64'(10 * (k + 1)));
        end
    endtask

    initial begin
        int b0, bb0, a0, d0, h0, hb0;
        logic seen;
        rst = 1'b1;
        start = 1'b0;
        ready_plain = 1'b1;
        bp_mode = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 32'hBAD0_0000 | 32'(i);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy_a), 64'd0);
        check("rst_done", 64'(done_a), 64'd0);
        check("rst_valid", 64'(valid_a), 64'd0);
        check("rst_addr", 64'(addr_a), 64'd0);
        check("rst_node", 64'(node_a), 64'd0);
        check("rst_score", 64'(score_a), 64'd0);
        check("rst_max_node", 64'(max_node_a), 64'd0);
        check("rst_max_score", 64'(max_score_a), 64'd0);
        @(posedge clk);
        #2 rst = 1'b0;

        // Basic scan
        load(10, 20, 30, 40);
        b0 = na; a0 = nal; d0 = done_cnt_a;
        pulse_start();
        wait_idle(d0);
        check_10n_beats("basic", b0);
        check("basic_done_cycle", 64'(done_abs - start_abs + 1), 64'd14);
        check("basic_first_valid", 64'(first_valid_abs - start_abs + 1), 64'd4);
        check("basic_done_count", 64'(done_cnt_a - d0), 64'd1);
        check("basic_max_node", 64'(max_node_a), 64'd4);
        check("basic_max_score", 64'(max_score_a), 64'd40);
        check("addr_count", 64'(nal - a0), 64'd4);
        for (int k = 0; k < 4; k++) check("addr_seq", 64'(alog[a0 + k]), 64'(101 + k));

        // Backpressure
        bp_mode = 1'b1;
        b0 = na; d0 = done_cnt_a; h0 = hold_cnt; hb0 = hold_bad;
        pulse_start();
        wait_idle(d0);
        bp_mode = 1'b0;
        check_10n_beats("bp", b0);
        check("bp_hold_cycles", 64'(hold_cnt - h0), 64'd20);
        check("bp_hold_stable", 64'(hold_bad - hb0), 64'd0);
        check("bp_done_count", 64'(done_cnt_a - d0), 64'd1);
        check("bp_done_cycle", 64'(done_abs - start_abs + 1), 64'd34);

        // Zero skip and ties
        load(0, 7, 0, 7);
        b0 = na; bb0 = nb; d0 = done_cnt_a;
        pulse_start();
        wait_idle(d0);
        check("zs_beats", 64'(na - b0), 64'd2);
        check("zs_node0", 64'(bn_a[b0]), 64'd2);
        check("zs_score0", 64'(bs_a[b0]), 64'd7);
        check("zs_node1", 64'(bn_a[b0 + 1]), 64'd4);
        check("zs_score1", 64'(bs_a[b0 + 1]), 64'd7);
        check("zs_max_node", 64'(max_node_a), 64'd2);
        check("zs_max_score", 64'(max_score_a), 64'd7);
        check("zs_done_cycle", 64'(done_abs - start_abs + 1), 64'd12);
        check("noskip_beats", 64'(nb - bb0), 64'd4);
        for (int k = 0; k < 4; k++) begin
            check("noskip_node", 64'(bn_b[bb0 + k]), 64'(k + 1));
            check("noskip_score", 64'(bs_b[bb0 + k]), (k % 2 == 1) ? 64'd7 : 64'd0);
        end
        check("noskip_max_node", 64'(max_node_b), 64'd2);

        // All zeros: no beats, shortest scan
        load(0, 0, 0, 0);
        b0 = na; bb0 = nb; d0 = done_cnt_a;
        pulse_start();
        wait_idle(d0);
        check("az_beats", 64'(na - b0), 64'd0);
        check("az_done_cycle", 64'(done_abs - start_abs + 1), 64'd10);
        check("az_max_node", 64'(max_node_a), 64'd0);
        check("az_max_score", 64'(max_score_a), 64'd0);
        check("az_noskip_beats", 64'(nb - bb0), 64'd4);

        // Start while busy
        load(10, 20, 30, 40);
        b0 = na; d0 = done_cnt_a;
        pulse_start();
        repeat (3) @(posedge clk);
        pulse_start();
        wait_idle(d0);
        repeat (4) @(negedge clk);
        check_10n_beats("sb", b0);
        check("sb_done_count", 64'(done_cnt_a - d0), 64'd1);
        check("sb_done_cycle", 64'(done_abs - start_abs + 1), 64'd14);

        // Reset mid-scan while a beat is pending
        ready_plain = 1'b0;
        d0 = done_cnt_a;
        pulse_start();
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (valid_a) begin
                seen = 1'b1;
                break;
            end
        end
        check("mr_valid_seen", 64'(seen), 64'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mr_valid", 64'(valid_a), 64'd0);
        check("mr_busy", 64'(busy_a), 64'd0);
        check("mr_addr", 64'(addr_a), 64'd0);
        check("mr_node", 64'(node_a), 64'd0);
        check("mr_score", 64'(score_a), 64'd0);
        check("mr_max_node", 64'(max_node_a), 64'd0);
        check("mr_max_score", 64'(max_score_a), 64'd0);
        #2 rst = 1'b0;
        ready_plain = 1'b1;
        repeat (4) @(negedge clk);
        check("mr_no_done", 64'(done_cnt_a - d0), 64'd0);
        b0 = na;
        pulse_start();
        wait_idle(d0);
        check_10n_beats("mr_rescan", b0);
        check("mr_done_count", 64'(done_cnt_a - d0), 64'd1);
        check("mr_done_cycle", 64'(done_abs - start_abs + 1), 64'd14);
        check("mr_max_node2", 64'(max_node_a), 64'd4);

        check("write_never", 64'(write_seen), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
